// File: rtl/aes_inv_mix_col_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_inv_mix_col_seq                                          |
// | Description : Iterative AES InvMixColumns engine. Accepts a 128-bit state  |
// |               over a valid/ready handshake, transforms it in place one     |
// |               column per clock and presents the result on a second         |
// |               valid/ready handshake.                                       |
// |               Optional macro AES_INV_MC_PARALLEL_EN: four column units,    |
// |               the whole state is transformed in a single CALC cycle.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module aes_inv_mix_col_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   // One column through the inverse MixColumns matrix; s0 is the MSB byte
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] s0, s1, s2, s3;
      s0 = c[31:24];
      s1 = c[23:16];
      s2 = c[15:8];
      s3 = c[7:0];
      return {mule(s0) ^ mulb(s1) ^ muld(s2) ^ mul9(s3),
              mul9(s0) ^ mule(s1) ^ mulb(s2) ^ muld(s3),
              muld(s0) ^ mul9(s1) ^ mule(s2) ^ mulb(s3),
              mulb(s0) ^ muld(s1) ^ mul9(s2) ^ mule(s3)};
   endfunction

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic [127:0] r_work;
   logic         w_accept;
   logic         w_calc_last;

   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign out_data = r_work;

`ifdef AES_INV_MC_PARALLEL_EN
   logic [127:0] w_par_res;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_col_unit
         assign w_par_res[127-32*gi -: 32] = inv_mix_col(r_work[127-32*gi -: 32]);
      end
   endgenerate

   // All four columns finish together, so CALC is always a single cycle
   assign w_calc_last = 1'b1;

   // Working register: capture on accept, whole-state update in CALC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work <= 128'h0;
      end else if (w_accept) begin
         r_work <= in_data;
      end else if (r_state == S_CALC) begin
         r_work <= w_par_res;
      end
   end
`else
   logic [1:0]  r_col;
   logic [31:0] w_col_in;
   logic [31:0] w_col_res;

   // Shared column unit fed by the column selected by r_col
   always_comb begin
      w_col_in = r_work[127:96];
      case (r_col)
         2'd0:    w_col_in = r_work[127:96];
         2'd1:    w_col_in = r_work[95:64];
         2'd2:    w_col_in = r_work[63:32];
         default: w_col_in = r_work[31:0];
      endcase
   end

   assign w_col_res   = inv_mix_col(w_col_in);
   assign w_calc_last = (r_col == 2'd3);

   // Working register and column counter; the counter wraps 3->0 on the last CALC edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work <= 128'h0;
         r_col  <= 2'd0;
      end else if (w_accept) begin
         r_work <= in_data;
         r_col  <= 2'd0;
      end else if (r_state == S_CALC) begin
         case (r_col)
            2'd0:    r_work[127:96] <= w_col_res;
            2'd1:    r_work[95:64]  <= w_col_res;
            2'd2:    r_work[63:32]  <= w_col_res;
            default: r_work[31:0]   <= w_col_res;
         endcase
         r_col <= r_col + 2'd1;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_state_nxt = S_CALC;
         S_CALC:  if (w_calc_last) w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from registered state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_mix_col_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_inv_mix_col_seq                                       |
// | Description : Self-checking bench for aes_inv_mix_col_seq: directed        |
// |               vectors, backpressure, back-to-back, async reset and a       |
// |               forward-MixColumns round trip.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_aes_inv_mix_col_seq;

`ifdef AES_INV_MC_PARALLEL_EN
   localparam int EXP_LAT    = 1;
   localparam int EXP_PERIOD = 3;
`else
   localparam int EXP_LAT    = 4;
   localparam int EXP_PERIOD = 6;
`endif

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   int checks = 0;
   int errors = 0;

   aes_inv_mix_col_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference forward MixColumns, used to build round-trip stimulus
   function automatic logic [7:0] m2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] fmc(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      return {m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3,
              m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3)};
   endfunction

   function automatic logic [127:0] fmc_state(input logic [127:0] s);
      return {fmc(s[127:96]), fmc(s[95:64]), fmc(s[63:32]), fmc(s[31:0])};
   endfunction

   // Push one state in, wait for out_valid, leave it in DONE (out_ready low)
   task automatic run_block(input logic [127:0] d, output logic [127:0] q, output int lat);
      int n;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q = out_data;
   endtask

   // Pulse out_ready for one edge and check the handshake returns to IDLE
   task automatic release_block(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, "_out_valid_drop"}, 128'(out_valid), 128'(0));
      chk({name, "_in_ready_rise"},  128'(in_ready),  128'(1));
   endtask

   initial begin
      logic [127:0] q;
      logic [127:0] held;
      logic [127:0] st;
      logic [127:0] res [2];
      int           acc [2];
      int           lat;
      int           nacc;
      int           nres;

      vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'hdb135345_f20a225c_01010101_d4d4d4d5};
      vecs[1] = '{128'h0, 128'h0};
      vecs[2] = '{128'h01000000_00000001_aaaaaaaa_ffffffff, 128'h0e090d0b_090d0b0e_aaaaaaaa_ffffffff};
      vecs[3] = '{128'h4d7ebdf8_c6c6c6c6_d5d5d7d6_9fdc589d, 128'h2d26314c_c6c6c6c6_d4d4d4d5_f20a225c};
      vecs[4] = '{128'h00010000_00000100_01000000_00000001, 128'h0b0e090d_0d0b0e09_0e090d0b_090d0b0e};
      vecs[5] = '{128'h80000000_00000000_00000000_00000000, 128'h41ecdaf7_00000000_00000000_00000000};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = 128'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready",  128'(in_ready),  128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_out_data",  out_data,        128'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         run_block(vecs[i].din, q, lat);
         chk($sformatf("vec%0d_data", i), q, vecs[i].dout);
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(EXP_LAT));
         release_block($sformatf("vec%0d", i));
      end

      // Backpressure: DONE held with out_ready low while inputs churn
      run_block(vecs[0].din, q, lat);
      held = q;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = i[0];
         in_data  = {4{$urandom}};
         @(posedge clk);
         #1;
         chk("bp_out_data",  out_data,         held);
         chk("bp_in_ready",  128'(in_ready),   128'(0));
         chk("bp_out_valid", 128'(out_valid),  128'(1));
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_block("bp");
      chk("bp_data_kept", out_data, vecs[0].dout);

      // Back-to-back with in_valid and out_ready held high
      acc[0] = 0; acc[1] = 0;
      res[0] = '0; res[1] = '0;
      nacc = 0;
      nres = 0;
      @(negedge clk);
      in_data   = {4{32'h4d7ebdf8}};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (nacc >= 1) in_data = {4{32'hc6c6c6c6}};
         if (in_valid && in_ready && nacc < 2) begin
            acc[nacc] = i;
            nacc++;
         end
         if (out_valid && out_ready && nres < 2) begin
            res[nres] = out_data;
            nres++;
         end
         if (nres == 2) break;
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("b2b_results", 128'(nres), 128'(2));
      chk("b2b_out0", res[0], {4{32'h2d26314c}});
      chk("b2b_out1", res[1], {4{32'hc6c6c6c6}});
      chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'(EXP_PERIOD));

      // Asynchronous reset after E2
      @(negedge clk);
      in_data  = {4{32'h8e4da1bc}};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 128'(out_valid), 128'(0));
      chk("arst_in_ready",  128'(in_ready),  128'(1));
      chk("arst_out_data",  out_data,        128'h0);
      @(negedge clk);
      rst = 1'b0;
      run_block({4{32'h01010101}}, q, lat);
      chk("post_rst_data",    q,          {4{32'h01010101}});
      chk("post_rst_latency", 128'(lat),  128'(EXP_LAT));
      release_block("post_rst");

      // Round trip through a reference forward MixColumns
      for (int i = 0; i < 1000; i++) begin
         st = {$urandom, $urandom, $urandom, $urandom};
         run_block(fmc_state(st), q, lat);
         chk($sformatf("roundtrip%0d", i), q, st);
         release_block("roundtrip");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
